// File: rtl/shift_req_arbiter.sv
// shift_req_arbiter
//   Shares one combinational barrel shifter among NREQ requesters using
//   round-robin arbitration. A granted operation is registered onto sh_*,
//   the shifter result is captured one cycle later, and it is held on rsp_*
//   until the consumer takes it. Only one operation is in flight at a time:
//   IDLE (grant) -> EXEC (shifter settles) -> RESP (handshake) -> IDLE.
// Ports
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        per-requester handshake (ready is one-hot, IDLE only)
//   req_data/req_amt/req_op    per-requester operand, amount, opcode (packed)
//   sh_a/sh_s/sh_opcode        registered operation toward the shifter
//   sh_y/sh_ovf                shifter result and overflow
//   rsp_valid/rsp_ready        result handshake
//   rsp_data/rsp_ovf/rsp_err   captured result, overflow, illegal-opcode flag
//   rsp_id                     index of the requester that issued the op
module shift_req_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [3*NREQ-1:0] req_amt,
  input  logic [3*NREQ-1:0] req_op,
  output logic [7:0]        sh_a,
  output logic [2:0]        sh_s,
  output logic [2:0]        sh_opcode,
  input  logic [7:0]        sh_y,
  input  logic              sh_ovf,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [7:0]        rsp_data,
  output logic              rsp_ovf,
  output logic              rsp_err,
  output logic [IDW-1:0]    rsp_id
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, id_q;
  logic [7:0]       sh_a_q;
  logic [2:0]       sh_s_q, sh_op_q;
  logic             rsp_valid_q, rsp_ovf_q, rsp_err_q;
  logic [7:0]       rsp_data_q;
  logic [IDW-1:0]   rsp_id_q;

  logic [NREQ-1:0][7:0] data_v;
  logic [NREQ-1:0][2:0] amt_v, op_v;
  assign data_v = req_data;
  assign amt_v  = req_amt;
  assign op_v   = req_op;

  // Round-robin search: lowest valid index at or above rr_ptr wins, otherwise
  // wrap to the lowest valid index overall. Descending loops leave the lowest hit.
  logic           hi_found, lo_found, gnt_found;
  logic [IDW-1:0] hi_idx, lo_idx, gnt_idx, ptr_nxt;

  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_found = 1'b1;
        lo_idx   = IDW'(i);
        if (i >= int'(rr_ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = IDW'(i);
        end
      end
    end
    gnt_found = lo_found;
    gnt_idx   = hi_found ? hi_idx : lo_idx;
    ptr_nxt   = (int'(gnt_idx) == NREQ-1) ? '0 : gnt_idx + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        // Gated by rst_n so no requester sees an accept while reset is held.
        if (gnt_found && rst_n) begin
          req_ready[gnt_idx] = 1'b1;
          state_d            = EXEC;
        end
      end
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Opcodes x11 have no shifter meaning; their result is suppressed.
  logic illegal_op;
  assign illegal_op = (sh_op_q[1:0] == 2'b11);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      sh_a_q      <= '0;
      sh_s_q      <= '0;
      sh_op_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (gnt_found) begin
          sh_a_q   <= data_v[gnt_idx];
          sh_s_q   <= amt_v[gnt_idx];
          sh_op_q  <= op_v[gnt_idx];
          id_q     <= gnt_idx;
          rr_ptr_q <= ptr_nxt;
        end
        EXEC: begin
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= illegal_op ? 8'h00 : sh_y;
          rsp_ovf_q   <= illegal_op ? 1'b0 : sh_ovf;
          rsp_err_q   <= illegal_op;
          rsp_id_q    <= id_q;
        end
        RESP: if (rsp_ready) rsp_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign sh_a      = sh_a_q;
  assign sh_s      = sh_s_q;
  assign sh_opcode = sh_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_id    = rsp_id_q;

endmodule
